reg_dump_reader: RTL



---
 rtl/reg_dump_pkg.sv | 14 +
 rtl/reg_dump_reader_if.sv | 27 ++
 rtl/reg_dump_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump reader.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } state_e;

  localparam int unsigned DEF_A    = 4;
  localparam int unsigned NUM_REGS = 2 ** DEF_A;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Dump beat stream (valid/ready) between reg_dump_reader and the readout path.
interface reg_dump_reader_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic         DumpValid;
  logic         DumpReady;
  logic [W-1:0] DumpData;
  logic [A-1:0] DumpIdx;
  logic         DumpLast;

  modport master (
    output DumpValid,
    output DumpData,
    output DumpIdx,
    output DumpLast,
    input  DumpReady
  );

  modport slave (
    input  DumpValid,
    input  DumpData,
    input  DumpIdx,
    input  DumpLast,
    output DumpReady
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks every register through the register-file read port and streams the values out.
// Optional trailing XOR checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  output logic [A-1:0]        Raddr,
  input  logic [W-1:0]        RdData,
  output logic                Busy,
  output logic                Done,
  reg_dump_reader_if.master   dump
);

  localparam logic [A-1:0] LAST_IDX = '1;

  state_e       state_q, state_d;
  logic [A-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [A-1:0] didx_q, didx_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] csum_q, csum_d;
  logic         csum_beat_q, csum_beat_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    didx_d  = didx_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
    csum_beat_d = csum_beat_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = READ;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d      = '0;
          csum_beat_d = 1'b0;
`endif
        end
      end

      READ: begin
        state_d = HOLD;
        valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        if (csum_beat_q) begin
          data_d = csum_q;
          didx_d = '0;
          last_d = 1'b1;
        end else begin
          data_d = RdData;
          didx_d = idx_q;
          last_d = 1'b0;
        end
`else
        data_d = RdData;
        didx_d = idx_q;
        last_d = (idx_q == LAST_IDX);
`endif
      end

      HOLD: begin
        if (dump.DumpReady) begin
          valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (last_q) begin
            state_d = DONE;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          end else if (idx_q == LAST_IDX) begin
            // Counter parks on the last index; the flag redirects READ to the checksum.
            state_d     = READ;
            csum_beat_d = 1'b1;
`endif
          end else begin
            state_d = READ;
            idx_d   = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      didx_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
      csum_beat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      didx_q  <= didx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_beat_q <= csum_beat_d;
`endif
    end
  end

  assign Raddr          = (state_q == READ || state_q == HOLD) ? idx_q : '0;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign dump.DumpValid = valid_q;
  assign dump.DumpData  = data_q;
  assign dump.DumpIdx   = didx_q;
  assign dump.DumpLast  = last_q;

endmodule
